// File: rtl/snd_dma_addr_if.sv
// Sound DMA bus bundle: CPU register port plus the memory fetch request/ack handshake.
interface snd_dma_addr_if;
  logic        cpu_we;
  logic [3:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        sreq;
  logic        fetch_ack;
  logic [15:0] fetch_data;

  modport master (
    output cpu_we, cpu_addr, cpu_wdata, fetch_ack, fetch_data,
    input  cpu_rdata, sreq
  );

  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, fetch_ack, fetch_data,
    output cpu_rdata, sreq
  );
endinterface

// File: rtl/snd_dma_addr.sv
// Sound DMA address counter, frame start/end shadows and sample word FIFO
// feeding the DAC; reloads or stops at frame end and pulses sint.
module snd_dma_addr #(
  parameter int FIFO_DEPTH = 4,
  parameter int REQ_FREE   = 2
) (
  input  logic          clk,
  input  logic          res,
  snd_dma_addr_if.slave bus,
  input  logic          sample_tick,
  output logic          sndon,
  output logic          sfrep,
  output logic [21:1]   snd,
  output logic [21:1]   sft,
  output logic [15:0]   sample_word,
  output logic          sample_valid,
  output logic          sint,
  output logic          underrun
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] REQ_V   = (AW+1)'(REQ_FREE);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [21:1]   start_q, end_q;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          sreq_q;

  logic          ctrl_wr, full, empty, pop, accept, frame_end, turn_on, flush, reload;
  logic          sndon_n;
  logic [21:1]   snd_inc, snd_n, sft_n;
  logic [AW:0]   count_n, free_n;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ctrl_wr   = bus.cpu_we && (bus.cpu_addr == 4'd0);
    full      = (count == DEPTH_V);
    empty     = (count == '0);
    pop       = sample_tick && !empty;
    // A full FIFO still takes the word when a tick frees a slot in the same cycle.
    accept    = sndon && bus.fetch_ack && (!full || sample_tick);
    snd_inc   = snd + 21'd1;
    frame_end = accept && (snd_inc == sft);
    turn_on   = ctrl_wr && bus.cpu_wdata[0] && !sndon;
    flush     = ctrl_wr && !bus.cpu_wdata[0];
    reload    = turn_on || (frame_end && sfrep);

    sndon_n = sndon;
    if (ctrl_wr)
      sndon_n = bus.cpu_wdata[0];
    else if (frame_end && !sfrep)
      sndon_n = 1'b0;

    snd_n = snd;
    sft_n = sft;
    if (reload) begin
      snd_n = start_q;
      sft_n = end_q;
    end else if (accept) begin
      snd_n = snd_inc;
    end

    count_n = count;
    if (flush)
      count_n = '0;
    else if (accept && !pop)
      count_n = count + ONE_C;
    else if (!accept && pop)
      count_n = count - ONE_C;
    free_n = DEPTH_V - count_n;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (res) begin
      start_q  <= '0;
      end_q    <= '0;
      snd      <= '0;
      sft      <= '0;
      sndon    <= 1'b0;
      sfrep    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sreq_q   <= 1'b0;
      sint     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (bus.cpu_we) begin
        case (bus.cpu_addr)
          4'd1:    start_q[21:16] <= bus.cpu_wdata[5:0];
          4'd2:    start_q[15:8]  <= bus.cpu_wdata;
          4'd3:    start_q[7:1]   <= bus.cpu_wdata[7:1];
          4'd4:    end_q[21:16]   <= bus.cpu_wdata[5:0];
          4'd5:    end_q[15:8]    <= bus.cpu_wdata;
          4'd6:    end_q[7:1]     <= bus.cpu_wdata[7:1];
          default: ;
        endcase
      end
      sndon <= sndon_n;
      if (ctrl_wr)
        sfrep <= bus.cpu_wdata[1];
      snd <= snd_n;
      sft <= sft_n;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + AW'(1);
        if (pop)    rd_ptr <= rd_ptr + AW'(1);
      end
      count  <= count_n;
      // Evaluated on next-state values so sreq moves in the same cycle as the state it reflects.
      sreq_q <= sndon_n && (free_n >= REQ_V) && (snd_n != sft_n);
      sint   <= frame_end;
      if (sample_tick && empty)
        underrun <= 1'b1;
      else if (ctrl_wr)
        underrun <= 1'b0;
    end
  end

  // NOTE: the word storage is deliberately not reset; the pointers alone define valid entries.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= bus.fetch_data;
  end

  assign bus.sreq     = sreq_q;
  assign sample_valid = !empty;
  assign sample_word  = empty ? 16'h0000 : mem[rd_ptr];

  always_comb begin
    bus.cpu_rdata = 8'h00;
    case (bus.cpu_addr)
      4'd0:    bus.cpu_rdata = {underrun, 5'd0, sfrep, sndon};
      4'd1:    bus.cpu_rdata = {2'b00, start_q[21:16]};
      4'd2:    bus.cpu_rdata = start_q[15:8];
      4'd3:    bus.cpu_rdata = {start_q[7:1], 1'b0};
      4'd4:    bus.cpu_rdata = {2'b00, end_q[21:16]};
      4'd5:    bus.cpu_rdata = end_q[15:8];
      4'd6:    bus.cpu_rdata = {end_q[7:1], 1'b0};
      4'd7:    bus.cpu_rdata = {2'b00, snd[21:16]};
      4'd8:    bus.cpu_rdata = snd[15:8];
      4'd9:    bus.cpu_rdata = {snd[7:1], 1'b0};
      default: ;
    endcase
  end
endmodule

// File: tb/tb_snd_dma_addr.sv
// Bench for snd_dma_addr: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_snd_dma_addr;
  localparam int          DEPTH    = 4;
  localparam int          REQ_FREE = 2;
  localparam int unsigned AMASK    = 32'h001F_FFFF;

  logic        clk = 1'b0;
  logic        res;
  logic        sample_tick;
  logic        sndon, sfrep, sample_valid, sint, underrun;
  logic [20:0] snd, sft;
  logic [15:0] sample_word;

  snd_dma_addr_if bus();

  snd_dma_addr #(.FIFO_DEPTH(DEPTH), .REQ_FREE(REQ_FREE)) dut (
    .clk          (clk),
    .res          (res),
    .bus          (bus),
    .sample_tick  (sample_tick),
    .sndon        (sndon),
    .sfrep        (sfrep),
    .snd          (snd),
    .sft          (sft),
    .sample_word  (sample_word),
    .sample_valid (sample_valid),
    .sint         (sint),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-address shadows, word counters, and a queue for the FIFO.
  bit          m_sndon, m_sfrep, m_under, m_sint, m_sreq;
  logic [21:0] m_start_b, m_end_b;
  int unsigned m_snd, m_sft;
  logic [15:0] m_fifo[$];

  function automatic logic [7:0] m_rdata(input logic [3:0] a);
    logic [31:0] sv;
    logic [21:0] snd_b;
    sv    = m_snd;
    snd_b = {sv[20:0], 1'b0};
    case (a)
      4'd0:    return {m_under, 5'd0, m_sfrep, m_sndon};
      4'd1:    return {2'b00, m_start_b[21:16]};
      4'd2:    return m_start_b[15:8];
      4'd3:    return {m_start_b[7:1], 1'b0};
      4'd4:    return {2'b00, m_end_b[21:16]};
      4'd5:    return m_end_b[15:8];
      4'd6:    return {m_end_b[7:1], 1'b0};
      4'd7:    return {2'b00, snd_b[21:16]};
      4'd8:    return snd_b[15:8];
      4'd9:    return {snd_b[7:1], 1'b0};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    bit          ctrl, empty, pop, accept, fend, reload;
    int unsigned nxt;
    logic [21:0] old_start_b, old_end_b;
    if (res) begin
      m_sndon = 0; m_sfrep = 0; m_under = 0; m_sint = 0; m_sreq = 0;
      m_start_b = '0; m_end_b = '0; m_snd = 0; m_sft = 0;
      m_fifo.delete();
      return;
    end
    ctrl   = bus.cpu_we && (bus.cpu_addr == 4'd0);
    empty  = (m_fifo.size() == 0);
    pop    = sample_tick && !empty;
    accept = m_sndon && bus.fetch_ack && ((m_fifo.size() < DEPTH) || sample_tick);
    nxt    = (m_snd + 1) & AMASK;
    fend   = accept && (nxt == m_sft);
    old_start_b = m_start_b;
    old_end_b   = m_end_b;

    if (pop)    void'(m_fifo.pop_front());
    if (accept) m_fifo.push_back(bus.fetch_data);
    if (ctrl)   m_under = 0;
    if (sample_tick && empty) m_under = 1;
    m_sint = fend;

    reload = (ctrl && bus.cpu_wdata[0] && !m_sndon) || (fend && m_sfrep);
    if (reload) begin
      m_snd = old_start_b[21:1];
      m_sft = old_end_b[21:1];
    end else if (accept) begin
      m_snd = nxt;
    end

    if (ctrl) begin
      m_sndon = bus.cpu_wdata[0];
      m_sfrep = bus.cpu_wdata[1];
      if (!bus.cpu_wdata[0]) m_fifo.delete();
    end else if (fend && !m_sfrep) begin
      m_sndon = 0;
    end

    if (bus.cpu_we) begin
      case (bus.cpu_addr)
        4'd1:    m_start_b[21:16] = bus.cpu_wdata[5:0];
        4'd2:    m_start_b[15:8]  = bus.cpu_wdata;
        4'd3:    m_start_b[7:1]   = bus.cpu_wdata[7:1];
        4'd4:    m_end_b[21:16]   = bus.cpu_wdata[5:0];
        4'd5:    m_end_b[15:8]    = bus.cpu_wdata;
        4'd6:    m_end_b[7:1]     = bus.cpu_wdata[7:1];
        default: ;
      endcase
    end

    m_sreq = m_sndon && ((DEPTH - m_fifo.size()) >= REQ_FREE) && (m_snd != m_sft);
  endtask

  task automatic compare();
    check("sndon",        sndon,         m_sndon);
    check("sfrep",        sfrep,         m_sfrep);
    check("snd",          snd,           m_snd);
    check("sft",          sft,           m_sft);
    check("sreq",         bus.sreq,      m_sreq);
    check("sint",         sint,          m_sint);
    check("underrun",     underrun,      m_under);
    check("cpu_rdata",    bus.cpu_rdata, m_rdata(bus.cpu_addr));
    check("sample_valid", sample_valid,  m_fifo.size() != 0);
    if (m_fifo.size() != 0)
      check("sample_word", sample_word, m_fifo[0]);
  endtask

  always @(posedge clk) begin
    model_step();
    #1 compare();
  end

  task automatic drive(input bit we, input logic [3:0] a, input logic [7:0] d,
                       input bit ack_i, input logic [15:0] fd, input bit tk);
    bus.cpu_we     = we;
    bus.cpu_addr   = a;
    bus.cpu_wdata  = d;
    bus.fetch_ack  = ack_i;
    bus.fetch_data = fd;
    sample_tick    = tk;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    drive(1'b1, a, d, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'd0, 8'h00, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic ack(input logic [15:0] fd, input bit tk);
    drive(1'b0, 4'd0, 8'h00, 1'b1, fd, tk);
  endtask

  task automatic tick();
    drive(1'b0, 4'd0, 8'h00, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic set_frame(input logic [21:0] sb, input logic [21:0] eb);
    wr(4'd1, {2'b00, sb[21:16]});
    wr(4'd2, sb[15:8]);
    wr(4'd3, sb[7:0]);
    wr(4'd4, {2'b00, eb[21:16]});
    wr(4'd5, eb[15:8]);
    wr(4'd6, eb[7:0]);
  endtask

  initial begin
    res = 1'b1;
    idle(3);
    check("rst_sndon",        sndon,        32'd0);
    check("rst_snd",          snd,          32'd0);
    check("rst_sft",          sft,          32'd0);
    check("rst_sreq",         bus.sreq,     32'd0);
    check("rst_sample_valid", sample_valid, 32'd0);
    check("rst_sample_word",  sample_word,  32'd0);
    check("rst_rdata",        bus.cpu_rdata, 32'd0);
    res = 1'b0;
    idle(1);

    // Frame 0x010000..0x010008, one-shot.
    set_frame(22'h010000, 22'h010008);
    wr(4'd0, 8'h01);
    check("t1_snd_load", snd, 32'h008000);
    check("t1_sft_load", sft, 32'h008004);
    check("t1_sndon",    sndon, 32'd1);
    drive(1'b0, 4'd7, 8'h00, 1'b0, 16'h0, 1'b0);
    check("t1_sreq_up",  bus.sreq, 32'd1);
    check("t1_rd_snd_hi", bus.cpu_rdata, 32'h01);
    for (int i = 0; i < 4; i++) begin
      ack(16'hA000 + 16'(i), 1'b0);
      if (i == 2) begin
        check("t1_sreq_occ3", bus.sreq, 32'd0);
        check("t1_snd_3",     snd,      32'h008003);
      end
    end
    check("t1_sint",   sint,        32'd1);
    check("t1_off",    sndon,       32'd0);
    check("t1_snd_end", snd,        32'h008004);
    check("t1_head",   sample_word, 32'hA000);
    idle(1);
    check("t1_sint_pulse", sint, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t1_drain_word", sample_word, 32'hA000 + i);
      tick();
    end
    check("t1_drained", sample_valid, 32'd0);
    tick();
    check("t1_underrun",    underrun,      32'd1);
    check("t1_rd_underrun", bus.cpu_rdata, 32'h80);
    wr(4'd0, 8'h00);
    check("t1_underrun_clr", underrun, 32'd0);

    // Repeat mode with the start shadow rewritten mid-frame.
    wr(4'd0, 8'h03);
    check("t3_snd_load", snd, 32'h008000);
    ack(16'hB000, 1'b0);
    ack(16'hB001, 1'b1);
    drive(1'b1, 4'd1, 8'h02, 1'b0, 16'h0, 1'b1);
    ack(16'hB002, 1'b1);
    ack(16'hB003, 1'b1);
    check("t3_reload_snd", snd,   32'h010000);
    check("t3_reload_sft", sft,   32'h008004);
    check("t3_still_on",   sndon, 32'd1);
    check("t3_sint",       sint,  32'd1);
    wr(4'd0, 8'h00);
    check("t3_off_sreq",  bus.sreq,     32'd0);
    check("t3_flushed",   sample_valid, 32'd0);

    // Full FIFO: drop without tick, accept with tick.
    set_frame(22'h000000, 22'h000020);
    wr(4'd0, 8'h01);
    for (int i = 0; i < 4; i++) ack(16'hC000 + 16'(i), 1'b0);
    check("t5_snd_full", snd,      32'd4);
    check("t5_sreq_full", bus.sreq, 32'd0);
    ack(16'hC0FF, 1'b0);
    check("t5_drop_snd",  snd,         32'd4);
    check("t5_drop_head", sample_word, 32'hC000);
    ack(16'hC100, 1'b1);
    check("t5_tick_snd",  snd,         32'd5);
    check("t5_tick_head", sample_word, 32'hC001);
    wr(4'd0, 8'h00);

    // Empty frame, then a frame crossing the 21-bit wrap.
    set_frame(22'h1FFFFE, 22'h1FFFFE);
    wr(4'd0, 8'h01);
    check("t6_snd_eq", snd,   32'h0FFFFF);
    check("t6_sft_eq", sft,   32'h0FFFFF);
    idle(2);
    check("t6_no_sreq", bus.sreq, 32'd0);
    check("t6_on",      sndon,    32'd1);
    check("t6_no_sint", sint,     32'd0);
    wr(4'd0, 8'h00);
    set_frame(22'h3FFFFC, 22'h000004);
    wr(4'd0, 8'h01);
    check("t6_wrap_start", snd, 32'h1FFFFE);
    ack(16'hD000, 1'b1);
    ack(16'hD001, 1'b1);
    check("t6_wrapped", snd, 32'h000000);
    ack(16'hD002, 1'b1);
    ack(16'hD003, 1'b1);
    check("t6_end_snd", snd,   32'h000002);
    check("t6_end_sint", sint, 32'd1);
    check("t6_end_off", sndon, 32'd0);

    // Randomized frames against the model.
    for (int f = 0; f < 40; f++) begin
      logic [20:0] sw, ew;
      int          len;
      wr(4'd0, 8'h00);
      if ($urandom_range(0, 5) == 0) sw = 21'h1FFFF0 + 21'($urandom_range(0, 15));
      else                           sw = 21'($urandom);
      len = $urandom_range(0, 10);
      ew  = sw + 21'(len);
      set_frame({sw, 1'b0}, {ew, 1'b0});
      wr(4'd0, {6'd0, 1'($urandom_range(0, 1)), 1'b1});
      for (int c = 0; c < 60; c++) begin
        bit          a, tk;
        logic [15:0] fd;
        tk = ($urandom_range(0, 2) == 0);
        fd = 16'($urandom);
        if ($urandom_range(0, 39) == 0) begin
          drive(1'b1, 4'd0, {6'd0, 2'($urandom)}, 1'b0, 16'h0, tk);
        end else if ($urandom_range(0, 29) == 0) begin
          drive(1'b1, 4'($urandom_range(1, 15)), 8'($urandom), 1'b0, 16'h0, tk);
        end else begin
          if (m_sreq) a = ($urandom_range(0, 3) != 0);
          else        a = m_sndon && (m_fifo.size() == DEPTH) && ($urandom_range(0, 3) == 0);
          drive(1'b0, 4'($urandom_range(0, 15)), 8'h00, a, fd, tk);
        end
      end
    end

    // Reset in the middle of a frame with an ack pending.
    wr(4'd0, 8'h00);
    set_frame(22'h000100, 22'h000140);
    wr(4'd0, 8'h03);
    ack(16'hE000, 1'b0);
    res = 1'b1;
    ack(16'hE001, 1'b0);
    check("rm_snd",   snd,          32'd0);
    check("rm_sndon", sndon,        32'd0);
    check("rm_sfrep", sfrep,        32'd0);
    check("rm_valid", sample_valid, 32'd0);
    res = 1'b0;
    drive(1'b0, 4'd2, 8'h00, 1'b0, 16'h0, 1'b0);
    check("rm_start_rd", bus.cpu_rdata, 32'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
